// File: rtl/sipo_frame_receiver_pkg.sv
// Shared framing definitions for the serial frame receiver and its PISO transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sipo_frame_receiver_pkg;

  // FSM state encodings, shared so the transmitter side decodes states identically.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DATA = ST_DATA,
    STOP = ST_STOP
  } frame_state_t;

  // Line levels that delimit a frame; the idle line sits at STOP_BIT.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sipo_frame_receiver_shift_core.sv
// WIDTH-bit serial-in shift register with synchronous clear and selectable direction.
// Latency: one bit per shift_en edge; q reflects the shifted value after that edge.
// Backpressure: none, shifts whenever shift_en is high.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clear      zero the register (takes priority over shift_en)
//   shift_en   shift serial_in in on this edge
//   serial_in  incoming bit
//   q          register contents
module sipo_shift_core #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_shifted;

  // MSB-first: bits enter at the bottom and migrate up, so the first bit
  // ends at q[WIDTH-1]. LSB-first: bits enter at the top and migrate down.
  generate
    if (WIDTH == 1) begin : g_single
      assign q_shifted = serial_in;
    end else if (MSB_FIRST) begin : g_msb
      assign q_shifted = {q[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign q_shifted = {serial_in, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= q_shifted;
    end
  end

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits, stop bit, into a valid/ready holding register.
// Latency: data_valid rises 1 clk after the stop-bit sample edge.
// Backpressure: one-deep holding register; a good frame arriving while it is full is dropped with an overrun pulse.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   serial_in   serial line, sampled only on edges with bit_en=1
//   bit_en      sample strobe
//   data_out    last accepted payload; data_valid flags it as unconsumed
//   data_ready  consumer takes data_out on a data_valid & data_ready edge
//   busy        receiver is inside a frame
//   frame_err   1-cycle pulse: stop bit was not STOP_BIT
//   overrun     1-cycle pulse: good frame dropped because holding register was full
module sipo_frame_receiver
  import sipo_frame_receiver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  frame_state_t     state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_q;
  logic             shift_clear;
  logic             shift_en;
  logic             stop_sample;

  logic stop_good;
  logic consume;
  logic load;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clear     (shift_clear),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .q         (shift_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_clear = 1'b0;
    shift_en    = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        if (bit_en && serial_in == START_BIT) begin
          state_nxt   = DATA;
          shift_clear = 1'b1;
        end
      end
      DATA: begin
        if (bit_en) begin
          shift_en = 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        // Return to IDLE whatever the stop bit is; the check only decides the outcome.
        if (bit_en) begin
          stop_sample = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter reaches WIDTH at the last data bit and is cleared by the next start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (shift_clear) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign stop_good = stop_sample && (serial_in == STOP_BIT);
  assign consume   = data_valid && data_ready;
  // A frame may load into a register being drained on the same edge.
  assign load      = stop_good && (!data_valid || data_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_sample && (serial_in != STOP_BIT);
      overrun   <= stop_good && data_valid && !data_ready;
      if (load) begin
        data_out   <= shift_q;
        data_valid <= 1'b1;
      end else if (consume) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/sipo_frame_receiver.md
SIPO_FRAME_RECEIVER -- requirements
Module: sipo_frame_receiver

Interface
REQ-001 Parameter WIDTH, default 4: number of data bits per frame.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first data bit received is data_out[WIDTH-1]; 0 = first bit is data_out[0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 serial_in  input  1  serial line, driven by the upstream PISO shift register's serial_out.
REQ-006 bit_en  input  1  sample strobe; serial_in is sampled only on edges where bit_en=1.
REQ-007 data_out  output  WIDTH  last accepted frame payload (holding register).
REQ-008 data_valid  output  1  data_out holds an unconsumed frame.
REQ-009 data_ready  input  1  consumer accepts data_out on an edge where data_valid=1 and data_ready=1.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
REQ-012 overrun  output  1  one-cycle pulse: good frame completed while the holding register was still full.

Function
REQ-013 Frame format on sampled bits: start bit = 1, then WIDTH data bits, then stop bit = 0; idle line = 0.
REQ-014 FSM states: IDLE, DATA, STOP.
REQ-015 IDLE -> DATA on a bit_en edge with serial_in=1; the bit counter clears to 0 and the shift register clears.
REQ-016 In DATA, each bit_en edge shifts serial_in into the shift register (direction per MSB_FIRST) and increments the counter; after the WIDTH-th bit, go to STOP.
REQ-017 Counter width is $clog2(WIDTH+1); the counter never wraps within a frame.
REQ-018 In STOP, the next bit_en edge samples the stop bit, and the FSM returns to IDLE on that edge regardless of the stop bit value.
REQ-019 Stop bit = 0 and data_valid=0 (or being consumed that same edge): load data_out with the shift register; data_valid = 1 from the next cycle. Latency = 1 clk after the stop-sample edge.
REQ-020 Stop bit = 0 and data_valid=1 and data_ready=0: discard the new frame, keep data_out unchanged, pulse overrun for 1 cycle.
REQ-021 Stop bit = 1: discard the frame, pulse frame_err for 1 cycle, leave data_out and data_valid unchanged.
REQ-022 data_valid clears on a data_valid & data_ready edge, unless a new frame loads on the same edge (REQ-019), in which case it stays 1 with the new data.
REQ-023 Edges with bit_en=0 change no FSM, counter or shift state; the handshake still operates.
REQ-024 Back-to-back frames: a start bit on the bit_en immediately after the stop bit is accepted.
REQ-025 data_out is stable while data_valid=1 and not consumed.

Reset
REQ-026 rst=1 immediately forces state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, busy=0, frame_err=0, overrun=0.
REQ-027 rst asserted mid-frame abandons the frame; no pulse is produced and no partial data appears on data_out.

Structure
REQ-028 FSM state encoding localparams (IDLE/DATA/STOP) and the frame constants START_BIT=1 and STOP_BIT=0 live in a shared package, shared with the PISO transmitter.
REQ-029 One sub-module: sipo_shift_core (WIDTH-bit shift register with shift enable, clear, and MSB_FIRST direction); FSM, counter and handshake stay in the top level.

Verification
REQ-030 Reset, then bit_en every cycle, serial sequence 1,1,1,0,1,0 (MSB_FIRST=1) -> data_out=4'b1101 and data_valid=1 one cycle after the stop sample; frame_err=0.
REQ-031 Same frame with MSB_FIRST=0 -> data_out=4'b1011.
REQ-032 Frame 1,0,1,1,0,1 (stop bit=1) -> frame_err pulses 1 cycle; data_valid stays 0.
REQ-033 Two back-to-back good frames 1101 then 0110, data_ready=0 -> data_out stays 4'b1101 and overrun pulses once; with data_ready=1 instead -> 0110 replaces 1101 and data_valid stays 1.
REQ-034 bit_en=1 only every 3rd cycle, frame 1101 -> same result as REQ-030; no state change on off cycles.
REQ-035 rst pulse after 2 data bits, then full frame 0011 -> only 4'b0011 ever appears on data_out; no frame_err or overrun pulse.
